ibex_scr_key_mgr: RTL and testbench

//  Multi-client scrambling-key request manager for scrambled RAMs (ICache tag/data banks and peers).

---
 rtl/ibex_scr_key_mgr.sv | 112 +++++++++++
 tb/tb_ibex_scr_key_mgr.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ibex_scr_key_mgr.sv
// rtl/ibex_scr_key_mgr.sv - multi-client scrambling key request manager
// Coalesces per-client invalidates into one req/ack exchange with the key source.
module ibex_scr_key_mgr #(
  parameter int unsigned       NumClients    = 2,
  parameter int unsigned       KeyW          = 128,
  parameter int unsigned       NonceW        = 64,
  parameter int unsigned       TimeoutCycles = 64,
  parameter logic [KeyW-1:0]   RstKey        = {32{4'hD}},
  parameter logic [NonceW-1:0] RstNonce      = 64'hBBBBEEEEEEEEFFFF
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumClients-1:0]        inval_req_i,
  output logic [NumClients-1:0]        key_valid_o,
  output logic [NumClients*KeyW-1:0]   key_o,
  output logic [NumClients*NonceW-1:0] nonce_o,
  output logic                         scr_req_o,
  input  logic                         scr_ack_i,
  input  logic [KeyW-1:0]              scr_key_i,
  input  logic [NonceW-1:0]            scr_nonce_i,
  output logic                         busy_o,
  output logic                         timeout_err_o
);

  localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast = (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;

  typedef enum logic {IDLE, REQ} state_e;

  state_e                       state_q, state_d;
  logic [NumClients-1:0]        pending_q, pending_d;
  logic [NumClients-1:0]        valid_q, valid_d;
  logic [NumClients*KeyW-1:0]   key_q, key_d;
  logic [NumClients*NonceW-1:0] nonce_q, nonce_d;
  logic [CntW-1:0]              cnt_q, cnt_d;
  logic                         req_q, busy_q, terr_q, terr_d;
  logic [NumClients-1:0]        want;
  logic                         timeout;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | inval_req_i;
    valid_d   = valid_q & ~inval_req_i;
    key_d     = key_q;
    nonce_d   = nonce_q;
    cnt_d     = cnt_q;
    terr_d    = terr_q;
    want      = pending_q | inval_req_i;
    timeout   = (TimeoutCycles != 0) && (cnt_q == CntLast);
    unique case (state_q)
      IDLE: begin
        if (want != '0) begin
          state_d = REQ;
          cnt_d   = '0;
        end
      end
      REQ: begin
        // An invalidate arriving with the ack is folded into that same ack.
        if (scr_ack_i) begin
          for (int c = 0; c < NumClients; c++) begin
            if (want[c]) begin
              key_d[c*KeyW +: KeyW]       = scr_key_i;
              nonce_d[c*NonceW +: NonceW] = scr_nonce_i;
              valid_d[c]                  = 1'b1;
            end
          end
          pending_d = '0;
          terr_d    = 1'b0;
          state_d   = IDLE;
        end else if (timeout) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pending_q <= '0;
      valid_q   <= '1;
      key_q     <= {NumClients{RstKey}};
      nonce_q   <= {NumClients{RstNonce}};
      cnt_q     <= '0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      key_q     <= key_d;
      nonce_q   <= nonce_d;
      cnt_q     <= cnt_d;
      req_q     <= (state_d == REQ);
      busy_q    <= (state_d == REQ) | (|pending_d);
      terr_q    <= terr_d;
    end
  end

  assign key_valid_o   = valid_q;
  assign key_o         = key_q;
  assign nonce_o       = nonce_q;
  assign scr_req_o     = req_q;
  assign busy_o        = busy_q;
  assign timeout_err_o = terr_q;

endmodule

// File: tb/tb_ibex_scr_key_mgr.sv
// tb/tb_ibex_scr_key_mgr.sv - scoreboard bench for ibex_scr_key_mgr
// Directed scenarios followed by randomized invalidate/ack/reset traffic.
module tb_ibex_scr_key_mgr;

  localparam int TO = 8;
  localparam logic [127:0] RST_KEY   = {32{4'hD}};
  localparam logic [63:0]  RST_NONCE = 64'hBBBBEEEEEEEEFFFF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   inval = '0;
  logic [1:0]   key_valid;
  logic [255:0] key;
  logic [127:0] nonce;
  logic         scr_req, scr_ack = 1'b0, busy, terr;
  logic [127:0] scr_key = '0;
  logic [63:0]  scr_nonce = '0;

  ibex_scr_key_mgr #(.NumClients(2), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .inval_req_i(inval), .key_valid_o(key_valid),
    .key_o(key), .nonce_o(nonce), .scr_req_o(scr_req), .scr_ack_i(scr_ack),
    .scr_key_i(scr_key), .scr_nonce_i(scr_nonce), .busy_o(busy), .timeout_err_o(terr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   v;
    logic [255:0] k;
    logic [127:0] n;
    logic         r, b, e;
  } exp_t;
  exp_t exp_q[$];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, want);
  endtask

  // Reference model: abstract view of who is waiting and how long the request has been open.
  logic [1:0]   m_valid;
  logic [127:0] m_key [2];
  logic [63:0]  m_nonce [2];
  logic [1:0]   m_pend;
  bit           m_inreq, m_terr;
  int           m_age;

  function automatic void model_reset();
    m_valid = 2'b11;
    for (int c = 0; c < 2; c++) begin
      m_key[c]   = RST_KEY;
      m_nonce[c] = RST_NONCE;
    end
    m_pend = '0; m_inreq = 0; m_terr = 0; m_age = 0;
  endfunction

  function automatic void model_step(input logic rn, input logic [1:0] iv, input logic ak,
                                     input logic [127:0] k, input logic [63:0] n);
    logic [1:0] want;
    if (!rn) begin
      model_reset();
      return;
    end
    want = m_pend | iv;
    if (m_inreq && ak) begin
      for (int c = 0; c < 2; c++)
        if (want[c]) begin
          m_key[c] = k; m_nonce[c] = n; m_valid[c] = 1'b1;
        end
      m_pend = '0; m_terr = 0; m_inreq = 0;
    end else begin
      m_valid = m_valid & ~iv;
      m_pend  = want;
      if (m_inreq) begin
        if (m_age == TO - 1) begin
          m_terr = 1; m_inreq = 0;
        end else m_age++;
      end else if (m_pend != 0) begin
        m_inreq = 1; m_age = 0;
      end
    end
  endfunction

  task automatic cyc(input logic rn, input logic [1:0] iv, input logic ak,
                     input logic [127:0] k, input logic [63:0] n);
    exp_t e;
    #1;
    rst_n = rn; inval = iv; scr_ack = ak; scr_key = k; scr_nonce = n;
    @(posedge clk);
    model_step(rn, iv, ak, k, n);
    e.v = m_valid;
    e.k = {m_key[1], m_key[0]};
    e.n = {m_nonce[1], m_nonce[0]};
    e.r = m_inreq;
    e.b = m_inreq || (m_pend != 0);
    e.e = m_terr;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 2'b00, 1'b0, '0, '0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("key_valid", 256'(key_valid), 256'(e.v));
      chk("key", key, e.k);
      chk("nonce", 256'(nonce), 256'(e.n));
      chk("scr_req", 256'(scr_req), 256'(e.r));
      chk("busy", 256'(busy), 256'(e.b));
      chk("timeout_err", 256'(terr), 256'(e.e));
    end
  end

  initial begin
    logic [127:0] k1, k2, k3, kr;
    logic [63:0]  nr;
    logic [1:0]   iv;
    logic         ak;
    model_reset();
    k1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    k2 = 128'hA5A5_0000_FFFF_1234_CAFE_BABE_0F0F_9999;
    k3 = 128'h3333_3333_3333_3333_3333_3333_3333_3333;

    // reset then idle
    cyc(1'b0, 2'b00, 1'b0, '0, '0);
    cyc(1'b0, 2'b00, 1'b0, '0, '0);
    idle(10);
    #2;
    chk("reset_key_const", key, {RST_KEY, RST_KEY});
    chk("reset_valid_const", 256'(key_valid), 256'(2'b11));

    // single client refresh, ack at t+3
    cyc(1'b1, 2'b01, 1'b0, '0, '0);
    idle(2);
    cyc(1'b1, 2'b00, 1'b1, k1, 64'h1);
    idle(3);
    #2;
    chk("k1_client0", 256'(key[127:0]), 256'(k1));

    // coalesced request served by one ack
    cyc(1'b1, 2'b01, 1'b0, '0, '0);
    idle(1);
    cyc(1'b1, 2'b10, 1'b0, '0, '0);
    idle(2);
    cyc(1'b1, 2'b00, 1'b1, k2, 64'h2);
    idle(3);

    // timeout and retry, then ack clears the error
    cyc(1'b1, 2'b10, 1'b0, '0, '0);
    idle(20);
    cyc(1'b1, 2'b00, 1'b1, k1, 64'h3);
    idle(3);

    // ack while idle is ignored
    cyc(1'b1, 2'b00, 1'b1, k3, 64'h4);
    idle(3);

    // reset mid-request, late ack ignored
    cyc(1'b1, 2'b01, 1'b0, '0, '0);
    idle(2);
    cyc(1'b0, 2'b00, 1'b0, '0, '0);
    idle(1);
    cyc(1'b1, 2'b00, 1'b1, k3, 64'h5);
    idle(3);

    // same-cycle inval and ack, repeat inval of pending client
    cyc(1'b1, 2'b01, 1'b0, '0, '0);
    cyc(1'b1, 2'b01, 1'b0, '0, '0);
    cyc(1'b1, 2'b10, 1'b1, k2, 64'h6);
    idle(3);

    for (int i = 0; i < 2000; i++) begin
      iv = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ak = m_inreq ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 19) == 0);
      kr = {$urandom, $urandom, $urandom, $urandom};
      nr = {$urandom, $urandom};
      cyc(($urandom_range(0, 499) != 0), iv, ak, kr, nr);
    end
    idle(2);

    @(negedge clk);
    #1;
    chk("queue_drain", 256'(exp_q.size()), 256'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
